wb_write_queue: RTL and testbench

//  Writeback-side producer for the 16x16 register file's single write port (DstReg/DstData/WriteReg).
//  - Accepts results from two sources: ALU and MEM load, each with a valid/ready handshake.
//  - Buffers them in an in-order FIFO and retires exactly one write per cycle to the register file.
//  - Exports a per-register pending mask so decode can stall on queued writes.

---
 rtl/wb_write_queue.sv | 138 +++++++++++++
 tb/tb_wb_write_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback queue: merges MEM and ALU results into an in-order FIFO that drives the
// register-file write port one entry per cycle. Optional forwarding search: WB_FORWARD_EN.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_reg,
    input  logic [15:0] mem_data,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_reg,
    input  logic [15:0] alu_data,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic [15:0] pending,
    output logic        full,
    output logic        empty,
    input  logic [3:0]  fwd_reg,
    output logic        fwd_hit,
    output logic [15:0] fwd_data
);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [3:0]    q_reg_q  [DEPTH];
    logic [3:0]    q_reg_d  [DEPTH];
    logic [15:0]   q_data_q [DEPTH];
    logic [15:0]   q_data_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] alu_slot;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free;
    logic [CW-1:0] reg_cnt_q [16];
    logic [CW-1:0] reg_cnt_d [16];
    logic [15:0]   pending_q, pending_d;
    logic          mem_push, alu_push, pop;

    // Readiness uses the start-of-cycle free count, so a retiring head never makes room this cycle.
    assign free      = DEPTH_C - count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign mem_ready = (free >= CW'(1));
    assign alu_ready = mem_valid ? (free >= CW'(2)) : (free >= CW'(1));
    assign mem_push  = mem_valid & mem_ready;
    assign alu_push  = alu_valid & alu_ready;
    assign pop       = ~empty;
    assign alu_slot  = wr_ptr_q + AW'(mem_push);

    assign WriteReg  = ~empty;
    assign DstReg    = empty ? 4'h0  : q_reg_q[rd_ptr_q];
    assign DstData   = empty ? 16'h0 : q_data_q[rd_ptr_q];
    assign pending   = pending_q;

    always_comb begin
        q_reg_d  = q_reg_q;
        q_data_d = q_data_q;
        // MEM takes the first free slot so it retires ahead of a same-cycle ALU result.
        if (mem_push) begin
            q_reg_d[wr_ptr_q]  = mem_reg;
            q_data_d[wr_ptr_q] = mem_data;
        end
        if (alu_push) begin
            q_reg_d[alu_slot]  = alu_reg;
            q_data_d[alu_slot] = alu_data;
        end
        wr_ptr_d = wr_ptr_q + AW'(mem_push) + AW'(alu_push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < 16; i++) begin
            reg_cnt_d[i] = reg_cnt_q[i]
                         + CW'(mem_push && (mem_reg == 4'(i)))
                         + CW'(alu_push && (alu_reg == 4'(i)))
                         - CW'(pop && (DstReg == 4'(i)));
            pending_d[i] = (reg_cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < 16; i++) reg_cnt_q[i] <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            reg_cnt_q <= reg_cnt_d;
        end
    end

    // Payload storage carries no reset; only slots inside count are ever observed.
    always_ff @(posedge clk) begin
        q_reg_q  <= q_reg_d;
        q_data_q <= q_data_d;
    end

`ifdef WB_FORWARD_EN
    logic [AW-1:0] fwd_idx;
    logic          fwd_hit_c;
    logic [15:0]   fwd_data_c;

    // Scan oldest to youngest so the last match, the one nearest the tail, wins.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = 16'h0;
        fwd_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + AW'(k);
            if ((CW'(k) < count_q) && (q_reg_q[fwd_idx] == fwd_reg)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = q_data_q[fwd_idx];
            end
        end
    end

    assign fwd_hit  = fwd_hit_c;
    assign fwd_data = fwd_data_c;
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_reg;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed + random bench for wb_write_queue with a FIFO scoreboard of expected retirements.
module tb_wb_write_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid;
    logic        mem_ready, alu_ready;
    logic [3:0]  mem_reg, alu_reg;
    logic [15:0] mem_data, alu_data;
    logic        WriteReg, full, empty, fwd_hit;
    logic [3:0]  DstReg, fwd_reg;
    logic [15:0] DstData, pending, fwd_data;

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   acc    = 0;

`ifdef WB_FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    wb_write_queue #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData), .pending(pending),
        .full(full), .empty(empty),
        .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle: drive, check outputs against the scoreboard, then advance the model.
    task automatic cycle(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                         input logic av, input logic [3:0] ar, input logic [15:0] ad);
        int          free;
        logic        emr, ear, ma, aa, fh;
        logic [15:0] pend, fd;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        #1;
        free = 4 - sb.size();
        emr  = (free >= 1);
        ear  = mv ? (free >= 2) : (free >= 1);
        pend = '0; fh = 1'b0; fd = '0;
        foreach (sb[k]) begin
            pend[sb[k].r] = 1'b1;
            if (sb[k].r == fwd_reg) begin
                fh = 1'b1;
                fd = sb[k].d;
            end
        end
        if (!FWD) begin
            fh = 1'b0;
            fd = '0;
        end
        chk("mem_ready", 32'(mem_ready), 32'(emr));
        chk("alu_ready", 32'(alu_ready), 32'(ear));
        chk("WriteReg", 32'(WriteReg), 32'(sb.size() != 0));
        chk("empty", 32'(empty), 32'(sb.size() == 0));
        chk("full", 32'(full), 32'(sb.size() == 4));
        chk("pending", 32'(pending), 32'(pend));
        chk("fwd_hit", 32'(fwd_hit), 32'(fh));
        chk("fwd_data", 32'(fwd_data), 32'(fd));
        if (sb.size() != 0) begin
            chk("DstReg", 32'(DstReg), 32'(sb[0].r));
            chk("DstData", 32'(DstData), 32'(sb[0].d));
        end
        ma  = mv & emr;
        aa  = av & ear;
        acc = acc + int'(ma) + int'(aa);
        @(posedge clk);
        if (sb.size() != 0) void'(sb.pop_front());
        if (ma) sb.push_back({mr, md});
        if (aa) sb.push_back({ar, ad});
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        fwd_reg = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_WriteReg", 32'(WriteReg), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        idle();

        // Single ALU write r3=BEEF, then queue drains.
        cycle(1'b0, 4'h0, 16'h0, 1'b1, 4'h3, 16'hBEEF);
        chk("alu_WriteReg", 32'(WriteReg), 32'd1);
        chk("alu_DstReg", 32'(DstReg), 32'd3);
        chk("alu_DstData", 32'(DstData), 32'hBEEF);
        chk("alu_pending3", 32'(pending), 32'h0008);
        idle();
        chk("alu_done_WriteReg", 32'(WriteReg), 32'd0);
        chk("alu_done_pending", 32'(pending), 32'd0);
        idle();

        // Dual push to r5: MEM retires first.
        cycle(1'b1, 4'h5, 16'h1111, 1'b1, 4'h5, 16'h2222);
        chk("dual_first", 32'(DstData), 32'h1111);
        idle();
        chk("dual_second", 32'(DstData), 32'h2222);
        chk("dual_pending5", 32'(pending), 32'h0020);
        idle();
        chk("dual_cleared", 32'(pending), 32'd0);
        idle();

        // Fill from empty with both valids, then free==1 backpressure.
        acc = 0;
        cycle(1'b1, 4'h1, 16'hA001, 1'b1, 4'h2, 16'hA002);
        cycle(1'b1, 4'h3, 16'hA003, 1'b1, 4'h4, 16'hA004);
        chk("fill_2cyc", 32'(acc), 32'd4);
        cycle(1'b1, 4'h6, 16'hA005, 1'b1, 4'h8, 16'hA006);
        cycle(1'b0, 4'h0, 16'h0, 1'b1, 4'h8, 16'hA006);
        chk("bp_acc", 32'(acc), 32'd6);
        repeat (5) idle();

        // Forwarding: youngest r7 entry wins.
        fwd_reg = 4'h7;
        cycle(1'b1, 4'h7, 16'hAAAA, 1'b1, 4'h7, 16'hBBBB);
        chk("fwd7_hit", 32'(fwd_hit), 32'(FWD));
        chk("fwd7_data", 32'(fwd_data), FWD ? 32'hBBBB : 32'h0);
        fwd_reg = 4'h2;
        #1;
        chk("fwd2_hit", 32'(fwd_hit), 32'd0);
        repeat (3) idle();

        // Asynchronous reset with three entries queued.
        fwd_reg = 4'h9;
        cycle(1'b1, 4'h9, 16'h0901, 1'b1, 4'hA, 16'h0A02);
        cycle(1'b1, 4'hB, 16'h0B03, 1'b1, 4'h9, 16'h0904);
        chk("pre_rst_cnt", 32'(sb.size()), 32'd3);
        mem_valid = 1'b0; alu_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_WriteReg", 32'(WriteReg), 32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_DstReg", 32'(DstReg), 32'd0);
        chk("arst_DstData", 32'(DstData), 32'd0);
        chk("arst_fwd_hit", 32'(fwd_hit), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();

        // Random traffic over a small register set to exercise duplicate ids.
        for (int n = 0; n < 80; n++) begin
            fwd_reg = 4'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom));
        end
        repeat (6) idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
